// File: rtl/fifo_medac_rd_checker_if.sv
// rtl/fifo_medac_rd_checker_if.sv - FIFO read-port bundle between the MEDAC FIFO and its read checker
//
// Signals:
//   rdata    : FIFO head word, valid while rempty_n is high
//   rempty_n : FIFO not empty
//   rinc     : pop strobe, driven by the checker
// Modports:
//   master : checker side (drives rinc)
//   slave  : FIFO side (drives rdata / rempty_n)
interface fifo_medac_rd_checker_if #(
    parameter int DSIZE = 40
);
    logic [DSIZE-1:0] rdata;
    logic             rempty_n;
    logic             rinc;

    modport master (
        input  rdata,
        input  rempty_n,
        output rinc
    );

    modport slave (
        output rdata,
        output rempty_n,
        input  rinc
    );
endinterface

// File: rtl/fifo_medac_rd_checker.sv
// rtl/fifo_medac_rd_checker.sv - read-side pattern checker draining the MEDAC async FIFO
//
// Ports:
//   rclk, rst_n    : read clock, asynchronous active-low reset
//   start          : level run enable (low->high starts a run, low aborts)
//   pattern_sel    : 0 = incrementing index, 1 = inverted index
//   rd_gap         : idle cycles inserted after each pop
//   target_cnt     : words to check, 0 = unbounded
//   rd_if          : FIFO read port (rdata, rempty_n in; rinc out)
//   busy, done     : run / finished status
//   err_sticky     : any mismatch seen this run
//   rd_cnt         : words popped this run
//   mismatch_cnt   : mismatching words this run (saturating)
//   first_err_idx  : word index of the first mismatch
//   first_err_data : rdata captured at the first mismatch
module fifo_medac_rd_checker #(
    parameter int DSIZE = 40
) (
    input  logic                     rclk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pattern_sel,
    input  logic [3:0]               rd_gap,
    input  logic [31:0]              target_cnt,
    fifo_medac_rd_checker_if.master  rd_if,
    output logic                     busy,
    output logic                     done,
    output logic                     err_sticky,
    output logic [31:0]              rd_cnt,
    output logic [31:0]              mismatch_cnt,
    output logic [31:0]              first_err_idx,
    output logic [DSIZE-1:0]         first_err_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         gap_cnt, gap_cnt_d;
    logic [31:0]        rd_cnt_d, mismatch_cnt_d, first_err_idx_d;
    logic [DSIZE-1:0]   first_err_data_d;
    logic               err_sticky_d;

    logic               pop;
    logic               word_bad;
    logic [31:0]        rd_cnt_inc;
    logic [DSIZE+31:0]  idx_wide;
    logic [DSIZE-1:0]   idx_ext;
    logic [DSIZE-1:0]   exp_word;

    // Padding with DSIZE zeros before slicing covers both DSIZE<32
    // (truncate) and DSIZE>=32 (zero-extend) without a generate.
    assign idx_wide   = {{DSIZE{1'b0}}, rd_cnt};
    assign idx_ext    = idx_wide[DSIZE-1:0];
    assign exp_word   = pattern_sel ? ~idx_ext : idx_ext;
    assign word_bad   = (rd_if.rdata != exp_word);
    assign rd_cnt_inc = rd_cnt + 32'd1;

    // Gating on live start means a falling start never pops a word.
    assign pop        = (state_q == RUN) && start && rd_if.rempty_n && (gap_cnt == 4'd0);
    assign rd_if.rinc = pop;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        state_d          = state_q;
        gap_cnt_d        = gap_cnt;
        rd_cnt_d         = rd_cnt;
        mismatch_cnt_d   = mismatch_cnt;
        err_sticky_d     = err_sticky;
        first_err_idx_d  = first_err_idx;
        first_err_data_d = first_err_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = RUN;
                    gap_cnt_d        = 4'd0;
                    rd_cnt_d         = 32'd0;
                    mismatch_cnt_d   = 32'd0;
                    err_sticky_d     = 1'b0;
                    first_err_idx_d  = 32'd0;
                    first_err_data_d = '0;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = DONE;
                end else if (pop) begin
                    rd_cnt_d  = rd_cnt_inc;
                    gap_cnt_d = rd_gap;
                    if (word_bad) begin
                        if (mismatch_cnt != 32'hFFFF_FFFF) begin
                            mismatch_cnt_d = mismatch_cnt + 32'd1;
                        end
                        err_sticky_d = 1'b1;
                        // err_sticky still low means this is the first bad word.
                        if (!err_sticky) begin
                            first_err_idx_d  = rd_cnt;
                            first_err_data_d = rd_if.rdata;
                        end
                    end
                    if ((target_cnt != 32'd0) && (rd_cnt_inc == target_cnt)) begin
                        state_d = DONE;
                    end
                end else if (gap_cnt != 4'd0) begin
                    gap_cnt_d = gap_cnt - 4'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gap_cnt        <= 4'd0;
            rd_cnt         <= 32'd0;
            mismatch_cnt   <= 32'd0;
            err_sticky     <= 1'b0;
            first_err_idx  <= 32'd0;
            first_err_data <= '0;
        end else begin
            state_q        <= state_d;
            gap_cnt        <= gap_cnt_d;
            rd_cnt         <= rd_cnt_d;
            mismatch_cnt   <= mismatch_cnt_d;
            err_sticky     <= err_sticky_d;
            first_err_idx  <= first_err_idx_d;
            first_err_data <= first_err_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_medac_rd_checker.sv
// tb/tb_fifo_medac_rd_checker.sv - directed self-checking bench for fifo_medac_rd_checker
module tb_fifo_medac_rd_checker;

    localparam int DSIZE = 40;

    logic              rclk;
    logic              rst_n;
    logic              start;
    logic              pattern_sel;
    logic [3:0]        rd_gap;
    logic [31:0]       target_cnt;
    logic              busy;
    logic              done;
    logic              err_sticky;
    logic [31:0]       rd_cnt;
    logic [31:0]       mismatch_cnt;
    logic [31:0]       first_err_idx;
    logic [DSIZE-1:0]  first_err_data;

    int n_checks;
    int n_fail;

    fifo_medac_rd_checker_if #(.DSIZE(DSIZE)) fif ();

    fifo_medac_rd_checker #(.DSIZE(DSIZE)) dut (
        .rclk           (rclk),
        .rst_n          (rst_n),
        .start          (start),
        .pattern_sel    (pattern_sel),
        .rd_gap         (rd_gap),
        .target_cnt     (target_cnt),
        .rd_if          (fif.master),
        .busy           (busy),
        .done           (done),
        .err_sticky     (err_sticky),
        .rd_cnt         (rd_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic go_idle();
        @(negedge rclk);
        start        = 1'b0;
        fif.rempty_n = 1'b0;
        repeat (2) @(negedge rclk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        pattern_sel  = 1'b0;
        rd_gap       = 4'd0;
        target_cnt   = 32'd0;
        fif.rdata    = '0;
        fif.rempty_n = 1'b1;
        repeat (2) @(negedge rclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (fif.rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc got %0b want 0", fif.rinc); end
        n_checks++; if (rd_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_rd_cnt got %0h want 0", rd_cnt); end
        n_checks++; if (mismatch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mismatch got %0h want 0", mismatch_cnt); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_sticky); end
        n_checks++; if (first_err_idx !== 32'd0 || first_err_data !== '0) begin n_fail++; $display("FAIL reset_first_err got %0h/%0h want 0/0", first_err_idx, first_err_data); end
        rst_n = 1'b1;
        @(negedge rclk);
        // FIFO non-empty but not running: still no pop.
        n_checks++; if (fif.rinc !== 1'b0) begin n_fail++; $display("FAIL idle_rinc got %0b want 0", fif.rinc); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int first_pop = -1;
        int last_pop = -1;
        int late_rinc = 0;
        @(negedge rclk);
        pattern_sel = 1'b0; rd_gap = 4'd0; target_cnt = 32'd16;
        fif.rempty_n = 1'b1; fif.rdata = '0; start = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge rclk);
            fif.rdata = DSIZE'(idx);
            #1;
            if (fif.rinc === 1'b1) begin
                if (idx >= 16) late_rinc++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                idx++;
            end
        end
        n_checks++; if (idx != 16) begin n_fail++; $display("FAIL b2b_pops got %0d want 16", idx); end
        n_checks++; if (first_pop != 0 || last_pop != 15) begin n_fail++; $display("FAIL b2b_window got %0d..%0d want 0..15", first_pop, last_pop); end
        n_checks++; if (late_rinc != 0) begin n_fail++; $display("FAIL b2b_late_rinc got %0d want 0", late_rinc); end
        n_checks++; if (rd_cnt !== 32'd16) begin n_fail++; $display("FAIL b2b_rd_cnt got %0d want 16", rd_cnt); end
        n_checks++; if (mismatch_cnt !== 32'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_errors got %0d/%0b want 0/0", mismatch_cnt, err_sticky); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done got done=%0b busy=%0b want 1/0", done, busy); end
        go_idle();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done got %0b want 0", done); end
    endtask

    task automatic test_gap();
        int idx = 0;
        int pops[$];
        int done_cyc = -1;
        @(negedge rclk);
        pattern_sel = 1'b0; rd_gap = 4'd3; target_cnt = 32'd4;
        fif.rempty_n = 1'b1; fif.rdata = '0; start = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge rclk);
            fif.rdata = DSIZE'(idx);
            #1;
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (fif.rinc === 1'b1) begin
                pops.push_back(cyc);
                idx++;
            end
        end
        n_checks++; if (pops.size() != 4) begin n_fail++; $display("FAIL gap_pops got %0d want 4", pops.size()); end
        if (pops.size() == 4) begin
            n_checks++;
            if (pops[1] - pops[0] != 4 || pops[2] - pops[1] != 4 || pops[3] - pops[2] != 4) begin
                n_fail++; $display("FAIL gap_spacing got %0d,%0d,%0d,%0d want spacing 4", pops[0], pops[1], pops[2], pops[3]);
            end
            n_checks++; if (done_cyc - pops[0] != 13) begin n_fail++; $display("FAIL gap_done_latency got %0d want 13", done_cyc - pops[0]); end
        end
        n_checks++; if (rd_cnt !== 32'd4 || mismatch_cnt !== 32'd0) begin n_fail++; $display("FAIL gap_counts got %0d/%0d want 4/0", rd_cnt, mismatch_cnt); end
        go_idle();
    endtask

    task automatic test_injected_errors();
        int idx = 0;
        logic [DSIZE-1:0] w;
        @(negedge rclk);
        pattern_sel = 1'b1; rd_gap = 4'd0; target_cnt = 32'd8;
        fif.rempty_n = 1'b1; fif.rdata = '0; start = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge rclk);
            w = DSIZE'(idx);
            w = ~w;
            if (idx == 5) w = '0;
            if (idx == 6) w = 40'h12_3456_789A;
            fif.rdata = w;
            #1;
            if (fif.rinc === 1'b1) idx++;
        end
        n_checks++; if (rd_cnt !== 32'd8 || done !== 1'b1) begin n_fail++; $display("FAIL err_rd_cnt got %0d done=%0b want 8/1", rd_cnt, done); end
        n_checks++; if (mismatch_cnt !== 32'd2) begin n_fail++; $display("FAIL err_mismatch got %0d want 2", mismatch_cnt); end
        n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", err_sticky); end
        n_checks++; if (first_err_idx !== 32'd5) begin n_fail++; $display("FAIL err_first_idx got %0d want 5", first_err_idx); end
        n_checks++; if (first_err_data !== 40'h0) begin n_fail++; $display("FAIL err_first_data got %0h want 0", first_err_data); end
        go_idle();
    endtask

    task automatic test_empty_stall();
        int idx = 0;
        int stall_left = 10;
        int stall_bad = 0;
        @(negedge rclk);
        pattern_sel = 1'b0; rd_gap = 4'd0; target_cnt = 32'd10;
        fif.rempty_n = 1'b1; fif.rdata = '0; start = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge rclk);
            if (idx == 4 && stall_left > 0) begin
                fif.rempty_n = 1'b0;
                fif.rdata    = 40'hFF_DEAD_BEEF;
                stall_left--;
                #1;
                if (fif.rinc !== 1'b0 || rd_cnt !== 32'd4) stall_bad++;
            end else begin
                fif.rempty_n = 1'b1;
                fif.rdata    = DSIZE'(idx);
                #1;
                if (fif.rinc === 1'b1) idx++;
            end
        end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad); end
        n_checks++; if (rd_cnt !== 32'd10 || done !== 1'b1) begin n_fail++; $display("FAIL stall_rd_cnt got %0d done=%0b want 10/1", rd_cnt, done); end
        n_checks++; if (mismatch_cnt !== 32'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL stall_no_skip got %0d/%0b want 0/0", mismatch_cnt, err_sticky); end
        go_idle();
    endtask

    task automatic test_abort_restart_reset();
        int idx = 0;
        @(negedge rclk);
        pattern_sel = 1'b0; rd_gap = 4'd0; target_cnt = 32'd0;
        fif.rempty_n = 1'b1; fif.rdata = '0; start = 1'b1;
        for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
            @(negedge rclk);
            fif.rdata = (idx == 1) ? 40'h55 : DSIZE'(idx);
            #1;
            if (fif.rinc === 1'b1) idx++;
        end
        @(negedge rclk);
        start = 1'b0;
        fif.rdata = DSIZE'(idx);
        #1;
        n_checks++; if (fif.rinc !== 1'b0) begin n_fail++; $display("FAIL abort_rinc got %0b want 0", fif.rinc); end
        @(negedge rclk);
        n_checks++; if (done !== 1'b1 || rd_cnt !== 32'd3) begin n_fail++; $display("FAIL abort_done got done=%0b rd_cnt=%0d want 1/3", done, rd_cnt); end
        n_checks++; if (mismatch_cnt !== 32'd1 || first_err_idx !== 32'd1) begin n_fail++; $display("FAIL abort_err got %0d/%0d want 1/1", mismatch_cnt, first_err_idx); end
        @(negedge rclk);
        start = 1'b1;
        fif.rdata = '0;
        @(negedge rclk);
        n_checks++; if (busy !== 1'b1 || rd_cnt !== 32'd0 || mismatch_cnt !== 32'd0 || err_sticky !== 1'b0) begin
            n_fail++; $display("FAIL restart_clear got busy=%0b rd=%0d mm=%0d err=%0b want 1/0/0/0", busy, rd_cnt, mismatch_cnt, err_sticky);
        end
        #1;
        n_checks++; if (fif.rinc !== 1'b1) begin n_fail++; $display("FAIL restart_rinc got %0b want 1", fif.rinc); end
        @(negedge rclk);
        fif.rdata = 40'd1;
        #1;
        n_checks++; if (rd_cnt !== 32'd1 || fif.rinc !== 1'b1) begin n_fail++; $display("FAIL prereset got rd=%0d rinc=%0b want 1/1", rd_cnt, fif.rinc); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (fif.rinc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl got rinc=%0b busy=%0b done=%0b want 0/0/0", fif.rinc, busy, done); end
        n_checks++; if (rd_cnt !== 32'd0 || mismatch_cnt !== 32'd0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL async_reset_cnt got %0d/%0d/%0b want 0/0/0", rd_cnt, mismatch_cnt, err_sticky); end
        @(negedge rclk);
        start = 1'b0;
        rst_n = 1'b1;
        go_idle();
    endtask

    task automatic test_saturation_wrap();
        @(negedge rclk);
        pattern_sel = 1'b0; rd_gap = 4'd0; target_cnt = 32'd0;
        fif.rempty_n = 1'b0; fif.rdata = '0; start = 1'b1;
        @(negedge rclk);
        force dut.rd_cnt = 32'hFFFF_FFFF;
        force dut.mismatch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        release dut.mismatch_cnt;
        fif.rempty_n = 1'b1;
        fif.rdata    = 40'hAB_0000_0001;
        #1;
        n_checks++; if (fif.rinc !== 1'b1) begin n_fail++; $display("FAIL sat_rinc got %0b want 1", fif.rinc); end
        @(negedge rclk);
        n_checks++; if (rd_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_rd_cnt got %0h want 0", rd_cnt); end
        n_checks++; if (mismatch_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_mismatch got %0h want ffffffff", mismatch_cnt); end
        n_checks++; if (first_err_idx !== 32'hFFFF_FFFF || first_err_data !== 40'hAB_0000_0001) begin
            n_fail++; $display("FAIL sat_first_err got %0h/%0h want ffffffff/ab00000001", first_err_idx, first_err_data);
        end
        fif.rdata = '0;
        @(negedge rclk);
        n_checks++; if (rd_cnt !== 32'd1 || mismatch_cnt !== 32'hFFFF_FFFF || busy !== 1'b1) begin
            n_fail++; $display("FAIL post_wrap got rd=%0h mm=%0h busy=%0b want 1/ffffffff/1", rd_cnt, mismatch_cnt, busy);
        end
        go_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_back_to_back();
        test_gap();
        test_injected_errors();
        test_empty_stall();
        test_abort_restart_reset();
        test_saturation_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
